benes_stim_harness: RTL and testbench
=====================================

// Module: benes_stim_harness
// PURPOSE
// - Parametrised stimulus/config harness around network_module (Benes permutation network).
// - Drives SIZE per-channel pattern generators into the network.
// - Manages switch settings through a shadow bank loaded by a valid/ready port, committed atomically.
// - Sequences runs with an IDLE/RUN/FLUSH FSM. Flags output words that are valid through the network latency.
// PARAMETERS
// - SIZE        8   channel count; power of 2, >=4
// - DATA_WIDTH  8   channel word width
// - NET_LAT     1   network_module i_port->o_port latency in clk cycles, >=0
// - Derived localparams: STAGE_NUM = 2*$clog2(SIZE)-1, SWITCH_NUM = SIZE/2, SW = $clog2(STAGE_NUM)
// PORTS
// - clk         in   1              clock
// - rst_n       in   1              async active-low reset
// - cfg_valid   in   1              shadow switch-row write request
// - cfg_ready   out  1              shadow write accepted when cfg_valid&&cfg_ready
// - cfg_stage   in   SW             stage index of write; values >= STAGE_NUM ignored
// - cfg_bits    in   SWITCH_NUM     switch settings for that stage
// - cfg_commit  in   1              pulse: copy shadow bank to active bank
// - step_we     in   1              write per-channel step
// - step_idx    in   $clog2(SIZE)   channel to update
// - step_val    in   DATA_WIDTH     signed step, two's complement
// - start       in   1              begin run
// - stop        in   1              end run
// - burst_len   in   16             words per run; 0 = unbounded
// - busy        out  1              FSM != IDLE
// - o_valid     out  1              o_port holds a generated word
// - o_port      out  DATA_WIDTH x SIZE   network outputs
// BEHAVIOUR
// - Reset: gen values 0; steps ch i<SIZE/2 = +(i+1), else -(i-SIZE/2+1). Both banks all-zero (straight-through).
// - Reset also: FSM IDLE, busy=0, o_valid=0, cfg_ready=1, valid pipe cleared. o_port follows the network.
// - Generator: in RUN, val_i <= val_i + step_i each cycle, mod 2^DATA_WIDTH (wrap, no saturation).
// - Generators hold in IDLE/FLUSH. Values are not cleared between runs.
// - step_we takes effect next clk. On the cycle it lands, that channel updates with the new step.
// - FSM: IDLE --start--> RUN (word count=0).
// - RUN --stop, or count==burst_len-1 with burst_len!=0--> FLUSH.
// - FLUSH lasts NET_LAT cycles (0 -> straight to IDLE), then IDLE.
// - start and stop in the same cycle: stop wins (IDLE stays IDLE; RUN->FLUSH). start outside IDLE ignored.
// - o_valid = RUN-qualified sample delayed NET_LAT cycles (shift register); the last valid word exits by the end of FLUSH.
// - Shadow writes accepted in any state. cfg_ready drops only on the cycle a commit is applied.
// - Commit: applied next clk if FSM IDLE. If RUN/FLUSH, held pending and applied on the first IDLE cycle.
// - Repeated commits while pending collapse into one, using the shadow at application time.
// - Active bank never changes while o_valid data is in flight.
// - Reset mid-run: everything returns to reset values immediately; pending commit dropped.
// CONFIGURATION
// - Macro BENES_HARNESS_PRBS_EN.
//   - Defined: adds input prbs_mode[SIZE]. A channel with its bit set replaces the counter with a Fibonacci LFSR.
//     - Taps: DATA_WIDTH=8 -> x^8+x^6+x^5+x^4+1, table in package.
//     - Seed = i+1. Advances only in RUN. step ignored for that channel.
//   - Undefined: port absent, counters only. Logic and behaviour identical to prbs_mode=0.
// STRUCTURE
// - Package BENES_HARNESS_PKG:
//   - state_e {IDLE,RUN,FLUSH}
//   - default_step(i) function
//   - LFSR tap table indexed by DATA_WIDTH
//   - row_t = logic [SWITCH_NUM-1:0]
// - Sub-module benes_chan_gen: one channel's counter/LFSR, step register and seed. Generated SIZE times.
// - network_module instantiated once, fed by the active bank; not modified.
// TESTING
// - Reset, no writes, start with burst_len=4, NET_LAT=1:
//   - o_port straight-through; ch0 sequence 1,2,3,4; ch7 sequence 0xFC,0xF8,0xF4,0xF0.
//   - o_valid high exactly 4 cycles; busy falls after FLUSH.
// - Write stage0 row 0xF, commit in IDLE:
//   - Next run shows pairs (0,1),(2,3),(4,5),(6,7) swapped. cfg_ready low exactly one cycle.
// - Commit during RUN (burst_len=0), stop 10 cycles later:
//   - All 10 valid words use the old routing; new routing visible from the next run.
// - step_val=0x7F on ch3, 3 words:
//   - 0x7F, 0xFE, 0x7D (wrap verified).
//   - Second run continues from 0x7D without clearing.
// - start+stop same cycle in IDLE -> no run; deassert rst_n mid-RUN -> o_valid=0 and busy=0 at once, generators back to reset values.
// - PRBS_EN defined, prbs_mode[0]=1, DATA_WIDTH=8:
//   - ch0 period 255, never 0x00.
//   - Other channels unchanged.

Source files
------------

// File: rtl/benes_harness_pkg.sv
// Shared types and helpers for the Benes stimulus harness: FSM state
// encoding, reset step values for the channel generators and a table of
// maximal-length Fibonacci LFSR taps indexed by word width.
package benes_harness_pkg;

  // Geometry of the default build (8 channels -> 4 switches per stage).
  localparam int DEF_SIZE       = 8;
  localparam int DEF_SWITCH_NUM = DEF_SIZE / 2;

  // One row of switch settings (one bit per 2x2 switch in a stage).
  typedef logic [DEF_SWITCH_NUM-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Lower half of the channels count up by i+1, upper half count down by
  // (i - size/2 + 1); the caller truncates to the word width.
  function automatic int default_step(input int i, input int size);
    if (i < size / 2) begin
      return i + 1;
    end
    return -(i - size / 2 + 1);
  endfunction

  // Feedback mask: bit k set means register bit k feeds the XOR.
  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      3:       return 64'h6;
      4:       return 64'hC;
      5:       return 64'h14;
      6:       return 64'h30;
      7:       return 64'h60;
      8:       return 64'hB8;        // x^8 + x^6 + x^5 + x^4 + 1
      16:      return 64'hB400;
      32:      return 64'h8020_0003;
      default: return (64'h1 << (width - 1)) | 64'h1;
    endcase
  endfunction

endpackage

// File: rtl/benes_chan_gen.sv
// One stimulus channel: a wrapping step counter and a Fibonacci LFSR.
// sample_o is the value the channel takes at the coming edge, so the word
// presented to the network on a RUN cycle is the freshly advanced value.
// The LFSR only advances while selected and running; the counter only
// advances while not selected and running.
module benes_chan_gen
  import benes_harness_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] STEP_RST   = '0,
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  run_i,
  input  logic                  prbs_i,
  input  logic                  step_we_i,
  input  logic [DATA_WIDTH-1:0] step_val_i,
  output logic [DATA_WIDTH-1:0] sample_o
);

  localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
  logic                  lfsr_fb;

  // Next values: counter wraps modulo 2^DATA_WIDTH, LFSR shifts left.
  always_comb begin
    step_d  = step_we_i ? step_val_i : step_q;
    cnt_d   = (run_i && !prbs_i) ? cnt_q + step_q : cnt_q;
    lfsr_fb = ^(lfsr_q & TAPS);
    lfsr_d  = (run_i && prbs_i) ? {lfsr_q[DATA_WIDTH-2:0], lfsr_fb} : lfsr_q;
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      step_q <= STEP_RST;
      lfsr_q <= SEED;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign sample_o = prbs_i ? lfsr_d : cnt_d;

endmodule

// File: rtl/network_module.sv
// Benes permutation network. Stage s exchanges channel pairs that differ in
// address bit b(s) = 0,1,..,n-1,..,1,0 (n = log2 SIZE); a set switch bit
// crosses its pair. All-zero settings give the identity permutation.
// Routing is combinational at the input, followed by NET_LAT register
// stages, so words already in the pipe are unaffected by setting changes.
module network_module #(
  parameter int  SIZE       = 8,
  parameter int  DATA_WIDTH = 8,
  parameter int  NET_LAT    = 1,
  localparam int LOG2       = $clog2(SIZE),
  localparam int STAGE_NUM  = 2 * LOG2 - 1,
  localparam int SWITCH_NUM = SIZE / 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]  sw_cfg_i,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0]       i_port,
  output logic [SIZE-1:0][DATA_WIDTH-1:0]       o_port
);

  logic [SIZE-1:0][DATA_WIDTH-1:0] routed;

  // Walk the stages, swapping each crossed pair in place (pairs are disjoint).
  always_comb begin : route
    logic [SIZE-1:0][DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0]           tmp;
    logic [LOG2-1:0]                 lo_i;
    logic [LOG2-1:0]                 hi_i;
    int b;
    int lo;
    cur  = i_port;
    tmp  = '0;
    lo_i = '0;
    hi_i = '0;
    b    = 0;
    lo   = 0;
    for (int s = 0; s < STAGE_NUM; s++) begin
      b = (s < LOG2) ? s : (2 * LOG2 - 2 - s);
      for (int k = 0; k < SWITCH_NUM; k++) begin
        lo   = ((k >> b) << (b + 1)) | (k & ((1 << b) - 1));
        lo_i = LOG2'(lo);
        hi_i = LOG2'(lo + (1 << b));
        if (sw_cfg_i[s][k]) begin
          tmp       = cur[lo_i];
          cur[lo_i] = cur[hi_i];
          cur[hi_i] = tmp;
        end
      end
    end
    routed = cur;
  end

  if (NET_LAT == 0) begin : g_comb
    assign o_port = routed;
  end else begin : g_pipe
    logic [NET_LAT-1:0][SIZE-1:0][DATA_WIDTH-1:0] pipe_q;

    // Output latency pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= routed;
        for (int k = 1; k < NET_LAT; k++) begin
          pipe_q[k] <= pipe_q[k-1];
        end
      end
    end

    assign o_port = pipe_q[NET_LAT-1];
  end

endmodule

// File: rtl/benes_stim_harness.sv
// Stimulus/configuration harness around network_module.
// - SIZE channel generators feed the network; IDLE/RUN/FLUSH FSM sequences
//   runs of burst_len words (0 = until stop) and o_valid marks generated
//   words as they leave the network NET_LAT cycles later.
// - Switch settings are written into a shadow bank and copied to the
//   active bank on commit, only while IDLE, so routing never changes under
//   words in flight. A commit seen during RUN/FLUSH is held pending.
// - Config handshake: a shadow row write happens on cycles where
//   cfg_valid && cfg_ready; cfg_ready is low only on the cycle a commit is
//   being applied, which keeps the shadow stable while it is copied.
// Optional feature: macro BENES_HARNESS_PRBS_EN adds prbs_mode[SIZE], which
// switches individual channels from counter to LFSR.
module benes_stim_harness
  import benes_harness_pkg::*;
#(
  parameter int  SIZE       = 8,
  parameter int  DATA_WIDTH = 8,
  parameter int  NET_LAT    = 1,
  localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1,
  localparam int SWITCH_NUM = SIZE / 2,
  localparam int SW         = $clog2(STAGE_NUM),
  localparam int IDX_W      = $clog2(SIZE)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [SW-1:0]                   cfg_stage,
  input  logic [SWITCH_NUM-1:0]           cfg_bits,
  input  logic                            cfg_commit,
  input  logic                            step_we,
  input  logic [IDX_W-1:0]                step_idx,
  input  logic [DATA_WIDTH-1:0]           step_val,
`ifdef BENES_HARNESS_PRBS_EN
  input  logic [SIZE-1:0]                 prbs_mode,
`endif
  input  logic                            start,
  input  logic                            stop,
  input  logic [15:0]                     burst_len,
  output logic                            busy,
  output logic                            o_valid,
  output logic [SIZE-1:0][DATA_WIDTH-1:0] o_port
);

  localparam logic [15:0] FLUSH_LAST = 16'((NET_LAT > 0) ? NET_LAT - 1 : 0);

  state_e                                state_q, state_d;
  logic [15:0]                           cnt_q, cnt_d;
  logic                                  run;
  logic [SIZE-1:0]                       prbs_sel;
  logic [SIZE-1:0][DATA_WIDTH-1:0]       gen_word;
  logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]  shadow_q, shadow_d;
  logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]  active_q, active_d;
  logic                                  pend_q, pend_d;
  logic                                  apply;

`ifdef BENES_HARNESS_PRBS_EN
  assign prbs_sel = prbs_mode;
`else
  assign prbs_sel = '0;
`endif

  // FSM state and shared word/flush counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: stop beats start; burst end and stop both lead to FLUSH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !stop) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 16'd1;
        if (stop || (burst_len != 16'd0 && cnt_q == burst_len - 16'd1)) begin
          cnt_d   = '0;
          state_d = (NET_LAT == 0) ? IDLE : FLUSH;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != IDLE);
    run  = (state_q == RUN);
  end

  // RUN qualifier delayed to line up with the network output.
  if (NET_LAT == 0) begin : g_vcomb
    assign o_valid = run;
  end else begin : g_vpipe
    logic [NET_LAT-1:0] vpipe_q;

    // Valid shift register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vpipe_q <= '0;
      end else begin
        vpipe_q[0] <= run;
        for (int k = 1; k < NET_LAT; k++) begin
          vpipe_q[k] <= vpipe_q[k-1];
        end
      end
    end

    assign o_valid = vpipe_q[NET_LAT-1];
  end

  // A commit (new or pending) is applied on an IDLE cycle.
  assign apply     = (state_q == IDLE) && (cfg_commit || pend_q);
  assign cfg_ready = !apply;

  // Shadow writes, bank copy and pending-commit tracking.
  always_comb begin
    shadow_d = shadow_q;
    for (int s = 0; s < STAGE_NUM; s++) begin
      if (cfg_valid && cfg_ready && (cfg_stage == SW'(s))) begin
        shadow_d[s] = cfg_bits;
      end
    end
    active_d = apply ? shadow_q : active_q;
    pend_d   = apply ? 1'b0 : (pend_q || cfg_commit);
  end

  // Configuration bank registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_chan
    localparam logic [DATA_WIDTH-1:0] STEP_RST = DATA_WIDTH'(default_step(i, SIZE));
    localparam logic [DATA_WIDTH-1:0] SEED     = DATA_WIDTH'(i + 1);

    benes_chan_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .STEP_RST   (STEP_RST),
      .SEED       (SEED)
    ) u_gen (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .run_i      (run),
      .prbs_i     (prbs_sel[i]),
      .step_we_i  (step_we && (step_idx == IDX_W'(i))),
      .step_val_i (step_val),
      .sample_o   (gen_word[i])
    );
  end

  network_module #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .NET_LAT    (NET_LAT)
  ) u_net (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_cfg_i (active_q),
    .i_port   (gen_word),
    .o_port   (o_port)
  );

endmodule

// File: tb/tb_benes_stim_harness.sv
// Testbench for benes_stim_harness (SIZE=8, DATA_WIDTH=8, NET_LAT=1).
// Expected network words are pushed when a RUN cycle is driven and popped
// by a negedge monitor whenever o_valid is seen.
module tb_benes_stim_harness;
  import benes_harness_pkg::*;

  localparam int SIZE    = 8;
  localparam int DW      = 8;
  localparam int NET_LAT = 1;
  localparam int SW      = 3;
  localparam int SWN     = 4;
  localparam int IW      = 3;
  localparam int W       = SIZE * DW;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [SW-1:0]            cfg_stage;
  logic [SWN-1:0]           cfg_bits;
  logic                     cfg_commit;
  logic                     step_we;
  logic [IW-1:0]            step_idx;
  logic [DW-1:0]            step_val;
  logic [SIZE-1:0]          prbs_mode;
  logic                     start;
  logic                     stop;
  logic [15:0]              burst_len;
  logic                     busy;
  logic                     o_valid;
  logic [SIZE-1:0][DW-1:0]  o_port;

  benes_stim_harness #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DW),
    .NET_LAT    (NET_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_stage  (cfg_stage),
    .cfg_bits   (cfg_bits),
    .cfg_commit (cfg_commit),
    .step_we    (step_we),
    .step_idx   (step_idx),
    .step_val   (step_val),
`ifdef BENES_HARNESS_PRBS_EN
    .prbs_mode  (prbs_mode),
`endif
    .start      (start),
    .stop       (stop),
    .burst_len  (burst_len),
    .busy       (busy),
    .o_valid    (o_valid),
    .o_port     (o_port)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_log[256];
  int           obs_n;
  int           vcnt;
  int           n_cmp;
  int           n_bad;

  // Reference model of generators and routing (stage-0 row only)
  logic [DW-1:0] m_cnt [SIZE];
  logic [DW-1:0] m_step[SIZE];
  logic [DW-1:0] m_lfsr[SIZE];
  logic          m_prbs[SIZE];
  row_t          m_active;
  row_t          m_shadow;
  logic          m_pend;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] chan_out(input int i);
    return m_prbs[i] ? m_lfsr[i] : m_cnt[i];
  endfunction

  function automatic logic [W-1:0] model_word();
    logic [W-1:0] w;
    int src;
    w = '0;
    for (int j = 0; j < SIZE; j++) begin
      src = m_active[j/2] ? (j ^ 1) : j;
      w[j*DW +: DW] = chan_out(src);
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SIZE; i++) begin
      m_cnt[i]  = '0;
      m_step[i] = (i < SIZE/2) ? DW'(i + 1) : DW'(8'd0 - 8'(i - SIZE/2 + 1));
      m_lfsr[i] = DW'(i + 1);
    end
    m_active = '0;
    m_shadow = '0;
    m_pend   = 1'b0;
  endtask

  // Advance the model by one RUN cycle and queue the resulting word.
  task automatic model_step();
    logic fb;
    for (int i = 0; i < SIZE; i++) begin
      if (m_prbs[i]) begin
        fb = m_lfsr[i][7] ^ m_lfsr[i][5] ^ m_lfsr[i][4] ^ m_lfsr[i][3];
        m_lfsr[i] = {m_lfsr[i][6:0], fb};
      end else begin
        m_cnt[i] = m_cnt[i] + m_step[i];
      end
    end
    exp_q.push_back(model_word());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: one shadow row write through the valid/ready port.
  task automatic cfg_write(input logic [SW-1:0] stg, input logic [SWN-1:0] bits);
    cfg_valid = 1'b1;
    cfg_stage = stg;
    cfg_bits  = bits;
    #1;
    chk("cfg_ready_wr", W'(cfg_ready), W'(1));
    tick();
    cfg_valid = 1'b0;
    if (stg == 3'd0) m_shadow = bits;
  endtask

  // Driver: a bounded run of n words, then check flush timing and counts.
  task automatic run_burst(input int n);
    int v0;
    v0        = vcnt;
    obs_n     = 0;
    burst_len = 16'(n);
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < n; c++) begin
      model_step();
      tick();
    end
    chk("flush_busy", W'(busy), W'(1));
    tick();
    chk("idle_busy", W'(busy), W'(0));
    if (m_pend) begin
      m_active = m_shadow;
      m_pend   = 1'b0;
    end
    tick();
    chk("valid_count", W'(vcnt - v0), W'(n));
    chk("queue_drained", W'(exp_q.size()), W'(0));
  endtask

  // Monitor: compare every valid output word against the queue head.
  always @(negedge clk) begin
    if (o_valid) begin
      vcnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_valid", W'(o_valid), W'(0));
      end else begin
        chk("word", o_port, exp_q.pop_front());
        if (obs_n < 256) obs_log[obs_n] = o_port;
        obs_n++;
      end
    end
  end

  initial begin
    int v0;
    int zeros;
    int ones;
    n_cmp      = 0;
    n_bad      = 0;
    vcnt       = 0;
    obs_n      = 0;
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_stage  = '0;
    cfg_bits   = '0;
    cfg_commit = 1'b0;
    step_we    = 1'b0;
    step_idx   = '0;
    step_val   = '0;
    prbs_mode  = '0;
    start      = 1'b0;
    stop       = 1'b0;
    burst_len  = '0;
    for (int i = 0; i < SIZE; i++) m_prbs[i] = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_valid", W'(o_valid), W'(0));
    chk("rst_cfg_ready", W'(cfg_ready), W'(1));
    chk("rst_port", o_port, W'(0));

    // Default steps, straight-through routing, burst of 4
    run_burst(4);
    chk("ch0_first", W'(obs_log[0][7:0]), W'(8'h01));
    chk("ch0_last", W'(obs_log[3][7:0]), W'(8'h04));
    chk("ch7_first", W'(obs_log[0][63:56]), W'(8'hFC));
    chk("ch7_last", W'(obs_log[3][63:56]), W'(8'hF0));
    chk("idle_port", o_port, model_word());

    // Stage-0 crossing committed in IDLE; out-of-range stage write ignored
    cfg_write(3'd0, 4'hF);
    cfg_write(3'd7, 4'hF);
    cfg_commit = 1'b1;
    #1;
    chk("commit_ready_low", W'(cfg_ready), W'(0));
    tick();
    cfg_commit = 1'b0;
    #1;
    chk("commit_ready_back", W'(cfg_ready), W'(1));
    m_active = m_shadow;
    tick();
    chk("idle_route", o_port, model_word());
    run_burst(3);

    // Commit during an unbounded run: old routing for all 10 words
    v0        = vcnt;
    burst_len = 16'd0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin
        cfg_valid = 1'b1;
        cfg_stage = 3'd0;
        cfg_bits  = 4'h0;
      end
      if (c == 3) begin
        cfg_valid  = 1'b0;
        m_shadow   = 4'h0;
        cfg_commit = 1'b1;
        #1;
        chk("ready_in_run", W'(cfg_ready), W'(1));
        m_pend = 1'b1;
      end
      if (c == 4) cfg_commit = 1'b0;
      if (c == 9) stop = 1'b1;
      model_step();
      tick();
    end
    stop = 1'b0;
    chk("stop_flush_busy", W'(busy), W'(1));
    chk("flush_cfg_ready", W'(cfg_ready), W'(1));
    tick();
    chk("pend_apply_ready", W'(cfg_ready), W'(0));
    tick();
    chk("pend_ready_back", W'(cfg_ready), W'(1));
    chk("run_valid_count", W'(vcnt - v0), W'(10));
    m_active = m_shadow;
    m_pend   = 1'b0;
    run_burst(2);

    // Reset in the middle of a run
    burst_len = 16'd0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) begin
      model_step();
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", W'(o_valid), W'(0));
    chk("midrst_busy", W'(busy), W'(0));
    exp_q.delete();
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_port", o_port, W'(0));

    // Step 0x7F on ch3: wraps, and the next run continues without clearing
    step_we  = 1'b1;
    step_idx = 3'd3;
    step_val = 8'h7F;
    tick();
    step_we   = 1'b0;
    m_step[3] = 8'h7F;
    run_burst(3);
    chk("ch3_w0", W'(obs_log[0][31:24]), W'(8'h7F));
    chk("ch3_w1", W'(obs_log[1][31:24]), W'(8'hFE));
    chk("ch3_w2", W'(obs_log[2][31:24]), W'(8'h7D));
    run_burst(2);
    chk("ch3_cont", W'(obs_log[0][31:24]), W'(8'hFC));

    // start and stop together in IDLE: no run
    v0    = vcnt;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", W'(busy), W'(0));
    repeat (3) tick();
    chk("startstop_novalid", W'(vcnt - v0), W'(0));

    // Shortest bounded burst
    run_burst(1);

`ifdef BENES_HARNESS_PRBS_EN
    // ch0 as LFSR: 255 distinct nonzero words, back to the seed after 255
    prbs_mode = 8'h01;
    m_prbs[0] = 1'b1;
    tick();
    run_burst(255);
    zeros = 0;
    ones  = 0;
    for (int k = 0; k < 255; k++) begin
      if (obs_log[k][7:0] == 8'h00) zeros++;
      if (obs_log[k][7:0] == 8'h01) ones++;
    end
    chk("prbs_first", W'(obs_log[0][7:0]), W'(8'h02));
    chk("prbs_nonzero", W'(zeros), W'(0));
    chk("prbs_seed_once", W'(ones), W'(1));
    chk("prbs_period", W'(obs_log[254][7:0]), W'(8'h01));
`else
    zeros = 0;
    ones  = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
